seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Frame-level controller that feeds a serial pattern detector from a parallel word stream.
- Accepts WORD_W-bit words over a valid/ready handshake and serialises them MSB-first into an internal overlapping Moore-style detector with a programmable PAT_W-bit pattern.
- Counts matches per frame and flags when a programmable threshold is reached.
- Sits between a word-oriented producer and status/interrupt logic, replacing hand-driven sequence_in stimulus with a sequenced, bounded frame.

Parameters:
WORD_W, 8, input word width (bits serialised per word)
PAT_W, 4, pattern length in bits (default pattern use: 4'b1011)
CNT_W, 8, match counter and threshold width

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
cfg_pattern  input  PAT_W  pattern to detect; latched on accepted start
cfg_threshold  input  CNT_W  match count that sets thresh_hit; latched on start; 0 disables
start  input  1  begin frame; honoured only in IDLE
stop  input  1  abort frame; honoured in any non-IDLE state
in_valid  input  1  producer word valid
in_data  input  WORD_W  word, bit WORD_W-1 shifted first
in_last  input  1  qualifies in_data as final word of frame
in_ready  output  1  controller can accept a word
busy  output  1  high in any state other than IDLE
detect_pulse  output  1  one-cycle pulse per match
match_count  output  CNT_W  matches in current/last frame, saturating
thresh_hit  output  1  sticky: match_count >= latched threshold (threshold != 0)
done  output  1  one-cycle pulse at normal frame end

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; history, fill counter, latched config and word register cleared.
- States: IDLE, ARM, WAIT, SHIFT, DONE.
- IDLE: in_ready=0. start=1 -> ARM. In this cycle latch cfg_pattern and cfg_threshold; clear match_count, thresh_hit, history, fill.
- ARM: one cycle; -> WAIT.
- WAIT: in_ready=1 (combinational from state). in_valid && in_ready -> capture in_data and in_last; bit index = WORD_W-1; -> SHIFT.
- SHIFT: one bit per cycle. On each edge:
  - hist <= {hist[PAT_W-2:0], word[idx]}.
  - fill <= min(fill+1, PAT_W).
  - idx decrements.
  - After the edge that shifts bit 0: -> DONE if captured last=1, else -> WAIT.
- DONE: done=1 for exactly one cycle; -> IDLE. match_count and thresh_hit hold until the next accepted start.
- Word throughput: one word per WORD_W+1 cycles. Back-to-back in_valid is accepted in the WAIT cycle following the final SHIFT.
- Detection (Moore, registered): at the shifting edge, detect_pulse <= (new fill == PAT_W) && (new hist == latched pattern).
  - detect_pulse is high for the cycle after the edge that shifted the completing bit; 0 in every non-SHIFT-updated cycle.
  - Matches overlap.
  - History persists across words within a frame, so cross-word matches count.
  - No match is possible before PAT_W bits have been shifted in the frame.
- match_count increments on the same edge detect_pulse is set; saturates at 2^CNT_W-1 (no wrap).
- thresh_hit is set on the same edge when the new count >= latched threshold and threshold != 0; sticky until next start.
- stop=1 in ARM/WAIT/SHIFT/DONE:
  - -> IDLE next edge; current word discarded; no done pulse.
  - A match completing on that same edge is still counted.
  - match_count and thresh_hit retained.
- stop and in_valid both high in WAIT: stop wins; word not accepted (in_ready is still 1 that cycle, but the producer must treat the word as dropped; the bench checks no count change).
- start while busy: ignored. stop in IDLE: ignored.
- cfg_* changes mid-frame have no effect.
- reset asserted mid-frame: immediate return to reset values.

Test Plan:
- pattern=4'b1011, threshold=0; start; word 8'b1011_0110, in_last=1 -> detect_pulse after bits 4 and 7; match_count=2; done pulses once; thresh_hit=0.
- Cross-word: word 8'b0000_0101 (last=0) then 8'b1000_0000 (last=1) -> exactly one detect, on the 9th shifted bit; match_count=1; in_ready low during each 8-cycle SHIFT.
- threshold=3; words 8'b1011_1011 (last=0) then 8'b1011_0000 (last=1) -> count 1,2,3; thresh_hit rises with the 3rd pulse and stays high after done until the next start.
- stop asserted on the 3rd SHIFT cycle of word 8'b1011_1011 -> IDLE next cycle; no done; match_count=0; a following start clears state and a new frame runs normally.
- CNT_W=2, pattern=4'b1111, word 8'hFF then 8'hFF (last) -> 13 matches; match_count saturates at 3.
- reset driven low mid-SHIFT, asynchronously between clock edges -> all outputs 0 immediately. start asserted while busy -> ignored, config not relatched.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_ctrl
//  Purpose  : Frame controller that serialises a valid/ready word stream
//             MSB-first into an overlapping Moore pattern detector, counts
//             matches per frame (saturating) and flags a sticky threshold hit.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [CNT_W-1:0]  cfg_threshold,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              detect_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              thresh_hit,
  output logic              done
);

  localparam int c_idx_w  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int c_fill_w = $clog2(PAT_W + 1);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_arm   = 3'd1;
  localparam logic [2:0] c_st_wait  = 3'd2;
  localparam logic [2:0] c_st_shift = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [CNT_W-1:0]    thr_q, thr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic [c_idx_w-1:0]  idx_q, idx_d;
  logic [PAT_W-1:0]    hist_q, hist_d;
  logic [c_fill_w-1:0] fill_q, fill_d;
  logic                det_q, det_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hit_q, hit_d;

  logic [PAT_W-1:0]    w_hist_new;
  logic [c_fill_w-1:0] w_fill_new;
  logic                w_match;
  logic [CNT_W-1:0]    w_cnt_inc;

  // Next history/fill/count values for the bit shifted on this edge
  always_comb begin
    w_hist_new = {hist_q[PAT_W-2:0], word_q[idx_q]};
    w_fill_new = (fill_q == c_fill_w'(PAT_W)) ? fill_q : fill_q + c_fill_w'(1);
    w_match    = (w_fill_new == c_fill_w'(PAT_W)) && (w_hist_new == pat_q);
    w_cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Frame sequencing, serialisation and match accounting
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    thr_d   = thr_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    det_d   = 1'b0;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    case (state_q)
      c_st_idle: begin
        if (start) begin
          state_d = c_st_arm;
          pat_d   = cfg_pattern;
          thr_d   = cfg_threshold;
          cnt_d   = '0;
          hit_d   = 1'b0;
          hist_d  = '0;
          fill_d  = '0;
        end
      end
      c_st_arm: begin
        state_d = stop ? c_st_idle : c_st_wait;
      end
      c_st_wait: begin
        // stop has priority: a word offered alongside it is dropped
        if (stop) begin
          state_d = c_st_idle;
        end else if (in_valid) begin
          word_d  = in_data;
          last_d  = in_last;
          idx_d   = c_idx_w'(WORD_W - 1);
          state_d = c_st_shift;
        end
      end
      c_st_shift: begin
        // The shift and match bookkeeping happen even on a stop edge
        hist_d = w_hist_new;
        fill_d = w_fill_new;
        idx_d  = idx_q - c_idx_w'(1);
        det_d  = w_match;
        if (w_match) begin
          cnt_d = w_cnt_inc;
          if ((thr_q != '0) && (w_cnt_inc >= thr_q)) begin
            hit_d = 1'b1;
          end
        end
        if (stop) begin
          state_d = c_st_idle;
        end else if (idx_q == '0) begin
          state_d = last_q ? c_st_done : c_st_wait;
        end
      end
      c_st_done: begin
        state_d = c_st_idle;
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= c_st_idle;
      pat_q   <= '0;
      thr_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      thr_q   <= thr_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
    end
  end

  // Outputs decoded from state or taken straight from registers
  always_comb begin
    in_ready     = (state_q == c_st_wait);
    busy         = (state_q != c_st_idle);
    done         = (state_q == c_st_done);
    detect_pulse = det_q;
    match_count  = cnt_q;
    thresh_hit   = hit_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detect_ctrl
//  Purpose  : Directed self-checking bench for seq_detect_ctrl
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] cfg_pattern;
  logic [7:0] cfg_threshold;
  logic [1:0] cfg_threshold2;
  logic       start, start2, stop, in_valid, in_last;
  logic [7:0] in_data;

  logic       in_ready1, busy1, det1, hit1, done1;
  logic [7:0] cnt1;
  logic       in_ready2, busy2, det2, hit2, done2;
  logic [1:0] cnt2;

  logic       sel;
  integer     vectors;
  integer     miscompares;

  wire        rdy  = sel ? in_ready2 : in_ready1;
  wire        bsy  = sel ? busy2 : busy1;
  wire        det  = sel ? det2 : det1;
  wire        hit  = sel ? hit2 : hit1;
  wire        dn   = sel ? done2 : done1;
  wire [7:0]  cnt  = sel ? {6'b0, cnt2} : cnt1;

  seq_detect_ctrl dut (
    .clock(clock), .reset(reset), .cfg_pattern(cfg_pattern),
    .cfg_threshold(cfg_threshold), .start(start), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready1), .busy(busy1), .detect_pulse(det1),
    .match_count(cnt1), .thresh_hit(hit1), .done(done1)
  );

  seq_detect_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .cfg_pattern(cfg_pattern),
    .cfg_threshold(cfg_threshold2), .start(start2), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready2), .busy(busy2), .detect_pulse(det2),
    .match_count(cnt2), .thresh_hit(hit2), .done(done2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!rdy && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'b0, rdy}, 32'd1);
  endtask

  task automatic do_start(input logic s, input logic [3:0] pat, input logic [7:0] thr);
    cfg_pattern   = pat;
    cfg_threshold = thr;
    if (s) start2 = 1'b1; else start = 1'b1;
    tick();
    start  = 1'b0;
    start2 = 1'b0;
    chk("arm_busy", {31'b0, bsy}, 32'd1);
    chk("arm_cnt_clear", {24'b0, cnt}, 32'd0);
    chk("arm_hit_clear", {31'b0, hit}, 32'd0);
    tick();
  endtask

  // Accept one word, then record detect/hit after each of the 8 shift edges
  task automatic send_word(input logic [7:0] d, input logic l,
                           output logic [7:0] dmask, output logic [7:0] hmask);
    logic rlow;
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    rlow     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rdy) rlow = 1'b0;
      tick();
      dmask[7-i] = det;
      hmask[7-i] = hit;
    end
    chk("ready_low_in_shift", {31'b0, rlow}, 32'd1);
  endtask

  initial begin
    logic [7:0] dm, hm;
    logic       seen;
    vectors = 0; miscompares = 0;
    sel = 1'b0; reset = 1'b0;
    cfg_pattern = 4'b0; cfg_threshold = 8'd0; cfg_threshold2 = 2'd0;
    start = 0; start2 = 0; stop = 0; in_valid = 0; in_last = 0; in_data = 8'd0;

    // Reset state
    tick(); tick();
    chk("rst_busy", {31'b0, busy1}, 32'd0);
    chk("rst_ready", {31'b0, in_ready1}, 32'd0);
    chk("rst_det", {31'b0, det1}, 32'd0);
    chk("rst_cnt", {24'b0, cnt1}, 32'd0);
    chk("rst_hit", {31'b0, hit1}, 32'd0);
    chk("rst_done", {31'b0, done1}, 32'd0);
    reset = 1'b1;
    tick();

    // Single word 1011_0110: matches after bits 4 and 7
    do_start(1'b0, 4'b1011, 8'd0);
    chk("wait_ready", {31'b0, in_ready1}, 32'd1);
    send_word(8'b1011_0110, 1'b1, dm, hm);
    chk("t1_detmask", {24'b0, dm}, 32'h12);
    chk("t1_cnt", {24'b0, cnt1}, 32'd2);
    chk("t1_hit", {31'b0, hit1}, 32'd0);
    chk("t1_done", {31'b0, done1}, 32'd1);
    tick();
    chk("t1_done_drop", {31'b0, done1}, 32'd0);
    chk("t1_idle", {31'b0, busy1}, 32'd0);
    chk("t1_cnt_hold", {24'b0, cnt1}, 32'd2);

    // Cross-word match on the 9th bit
    do_start(1'b0, 4'b1011, 8'd0);
    send_word(8'b0000_0101, 1'b0, dm, hm);
    chk("t2_w1_detmask", {24'b0, dm}, 32'h00);
    chk("t2_ready_after_shift", {31'b0, in_ready1}, 32'd1);
    send_word(8'b1000_0000, 1'b1, dm, hm);
    chk("t2_w2_detmask", {24'b0, dm}, 32'h80);
    chk("t2_cnt", {24'b0, cnt1}, 32'd1);
    chk("t2_done", {31'b0, done1}, 32'd1);
    tick();

    // Threshold 3 reached by the third match, sticky past done
    do_start(1'b0, 4'b1011, 8'd3);
    send_word(8'b1011_1011, 1'b0, dm, hm);
    chk("t3_w1_detmask", {24'b0, dm}, 32'h11);
    chk("t3_w1_cnt", {24'b0, cnt1}, 32'd2);
    chk("t3_w1_hitmask", {24'b0, hm}, 32'h00);
    send_word(8'b1011_0000, 1'b1, dm, hm);
    chk("t3_w2_detmask", {24'b0, dm}, 32'h10);
    chk("t3_w2_hitmask", {24'b0, hm}, 32'h1F);
    chk("t3_cnt", {24'b0, cnt1}, 32'd3);
    tick();
    tick();
    chk("t3_hit_sticky", {31'b0, hit1}, 32'd1);
    chk("t3_cnt_sticky", {24'b0, cnt1}, 32'd3);
    do_start(1'b0, 4'b1011, 8'd0);

    // Stop on the third shift cycle of 1011_1011
    wait_ready();
    in_valid = 1'b1; in_data = 8'b1011_1011; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_stop_idle", {31'b0, busy1}, 32'd0);
    chk("t4_stop_cnt", {24'b0, cnt1}, 32'd0);
    seen = done1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done1) seen = 1'b1;
    end
    chk("t4_no_done", {31'b0, seen}, 32'd0);

    // Stop and word offered together in WAIT: word dropped
    do_start(1'b0, 4'b1011, 8'd0);
    stop = 1'b1; in_valid = 1'b1; in_data = 8'b1011_0110; in_last = 1'b1;
    tick();
    stop = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("t5_stop_wins_idle", {31'b0, busy1}, 32'd0);
    tick(); tick(); tick();
    chk("t5_still_idle", {31'b0, busy1}, 32'd0);
    chk("t5_cnt", {24'b0, cnt1}, 32'd0);

    // New frame with start/cfg wiggled while busy: must be ignored
    do_start(1'b0, 4'b1011, 8'd0);
    start = 1'b1; cfg_pattern = 4'b1101; cfg_threshold = 8'd1;
    send_word(8'b1011_0110, 1'b1, dm, hm);
    start = 1'b0;
    chk("t6_detmask", {24'b0, dm}, 32'h12);
    chk("t6_cnt", {24'b0, cnt1}, 32'd2);
    chk("t6_hit", {31'b0, hit1}, 32'd0);
    chk("t6_done", {31'b0, done1}, 32'd1);
    tick();

    // CNT_W=2 instance: 13 matches of 1111 saturate at 3
    sel = 1'b1;
    do_start(1'b1, 4'b1111, 8'd0);
    send_word(8'hFF, 1'b0, dm, hm);
    chk("t7_w1_detmask", {24'b0, dm}, 32'h1F);
    send_word(8'hFF, 1'b1, dm, hm);
    chk("t7_w2_detmask", {24'b0, dm}, 32'hFF);
    chk("t7_cnt_sat", {24'b0, cnt}, 32'd3);
    chk("t7_hit", {31'b0, hit}, 32'd0);
    chk("t7_done", {31'b0, dn}, 32'd1);
    tick();
    sel = 1'b0;

    // Asynchronous reset mid-SHIFT
    do_start(1'b0, 4'b1011, 8'd0);
    wait_ready();
    in_valid = 1'b1; in_data = 8'b1011_0110; in_last = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t8_pre_det", {31'b0, det1}, 32'd1);
    chk("t8_pre_cnt", {24'b0, cnt1}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("t8_busy", {31'b0, busy1}, 32'd0);
    chk("t8_ready", {31'b0, in_ready1}, 32'd0);
    chk("t8_det", {31'b0, det1}, 32'd0);
    chk("t8_cnt", {24'b0, cnt1}, 32'd0);
    chk("t8_hit", {31'b0, hit1}, 32'd0);
    chk("t8_done", {31'b0, done1}, 32'd0);
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("t8_after_idle", {31'b0, busy1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
